// File: rtl/count_sample_buffer_if.sv
// Bus between the BCD pulse counter / TFT read path and count_sample_buffer.
// Master drives digits, strobes and read requests; slave returns samples and status.
interface count_sample_buffer_if #(
    parameter int AW = 7,
    parameter int BW = 27
);
    logic          en;
    logic [3:0]    d0, d1, d2, d3, d4, d5, d6, d7;
    logic          ovf;
    logic          upd;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [BW:0]   rd_data;
    logic          rd_valid;
    logic [AW-1:0] wr_ptr;
    logic          sample_stb;
    logic          frame_done;
    logic [BW-1:0] frame_peak;
    logic          busy;
    logic          drop_err;

    modport master (
        output en, d0, d1, d2, d3, d4, d5, d6, d7, ovf, upd, rd_en, rd_addr,
        input  rd_data, rd_valid, wr_ptr, sample_stb, frame_done, frame_peak, busy, drop_err
    );

    modport slave (
        input  en, d0, d1, d2, d3, d4, d5, d6, d7, ovf, upd, rd_en, rd_addr,
        output rd_data, rd_valid, wr_ptr, sample_stb, frame_done, frame_peak, busy, drop_err
    );
endinterface

// File: rtl/count_sample_buffer.sv
// Snapshots the 8-digit BCD count on each window strobe, converts it to binary
// MSD-first with a x10 accumulator, and stores it in a ring buffer with peak tracking.
module count_sample_buffer #(
    parameter int DEPTH = 120,
    parameter int AW    = 7,
    parameter int BW    = 27
) (
    input logic                 clk,
    input logic                 rst_n,
    count_sample_buffer_if.slave bus
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [BW-1:0] SAT_COUNT = BW'(99_999_999);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [7:0][3:0] snap_q, snap_d;
    logic            snap_sat_q, snap_sat_d;
    logic [BW-1:0]   acc_q, acc_d;
    logic [2:0]      idx_q, idx_d;
    logic            ovf_seen_q, ovf_seen_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [BW-1:0]   run_peak_q, run_peak_d;
    logic [BW-1:0]   frame_peak_q, frame_peak_d;
    logic            sample_stb_q, sample_stb_d;
    logic            frame_done_q, frame_done_d;
    logic            drop_err_q, drop_err_d;
    logic [BW:0]     rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;

    logic [BW:0]     mem [DEPTH];
    logic [BW-1:0]   store_count;
    logic [BW-1:0]   peak_max;
    logic            wr_en;

    always_comb begin
        store_count = snap_sat_q ? SAT_COUNT : acc_q;
        peak_max    = (store_count > run_peak_q) ? store_count : run_peak_q;
        wr_en       = bus.en && (state_q == WRITE);
    end

    // NOTE: every variable gets its default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        snap_sat_d   = snap_sat_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        ovf_seen_d   = ovf_seen_q | bus.ovf;
        wr_ptr_d     = wr_ptr_q;
        run_peak_d   = run_peak_q;
        frame_peak_d = frame_peak_q;
        sample_stb_d = 1'b0;
        frame_done_d = 1'b0;
        drop_err_d   = drop_err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.upd) begin
                    // A carry coinciding with the strobe belongs to the window being closed.
                    snap_d     = {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};
                    snap_sat_d = ovf_seen_q | bus.ovf;
                    ovf_seen_d = 1'b0;
                    acc_d      = '0;
                    idx_d      = 3'd7;
                    state_d    = CONV;
                end
            end
            CONV: begin
                acc_d = (acc_q << 3) + (acc_q << 1) + BW'(snap_q[idx_q]);
                idx_d = idx_q - 3'd1;
                if (idx_q == 3'd0) state_d = WRITE;
            end
            WRITE: begin
                sample_stb_d = 1'b1;
                state_d      = IDLE;
                if (wr_ptr_q == LAST_ADDR) begin
                    wr_ptr_d     = '0;
                    frame_done_d = 1'b1;
                    frame_peak_d = peak_max;
                    run_peak_d   = '0;
                end else begin
                    wr_ptr_d   = wr_ptr_q + AW'(1);
                    run_peak_d = peak_max;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.upd && (state_q != IDLE)) drop_err_d = 1'b1;

        if (!bus.en) begin
            state_d      = IDLE;
            snap_d       = '0;
            snap_sat_d   = 1'b0;
            acc_d        = '0;
            idx_d        = '0;
            ovf_seen_d   = 1'b0;
            wr_ptr_d     = '0;
            run_peak_d   = '0;
            frame_peak_d = '0;
            sample_stb_d = 1'b0;
            frame_done_d = 1'b0;
            drop_err_d   = 1'b0;
        end
    end

    // Read port is independent of en so the display can keep scanning old data.
    always_comb begin
        rd_valid_d = bus.rd_en;
        rd_data_d  = rd_data_q;
        if (bus.rd_en) rd_data_d = (bus.rd_addr <= LAST_ADDR) ? mem[bus.rd_addr] : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            snap_q       <= '0;
            snap_sat_q   <= 1'b0;
            acc_q        <= '0;
            idx_q        <= '0;
            ovf_seen_q   <= 1'b0;
            wr_ptr_q     <= '0;
            run_peak_q   <= '0;
            frame_peak_q <= '0;
            sample_stb_q <= 1'b0;
            frame_done_q <= 1'b0;
            drop_err_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            snap_sat_q   <= snap_sat_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            ovf_seen_q   <= ovf_seen_d;
            wr_ptr_q     <= wr_ptr_d;
            run_peak_q   <= run_peak_d;
            frame_peak_q <= frame_peak_d;
            sample_stb_q <= sample_stb_d;
            frame_done_q <= frame_done_d;
            drop_err_q   <= drop_err_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    // NOTE: the sample memory has no reset so it maps onto a plain block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= {snap_sat_q, store_count};
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.wr_ptr     = wr_ptr_q;
    assign bus.sample_stb = sample_stb_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_peak = frame_peak_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.drop_err   = drop_err_q;

endmodule

// File: tb/tb_count_sample_buffer.sv
// Self-checking bench for count_sample_buffer: table vectors, hand-written corner
// sequences and randomized samples against a decimal-arithmetic reference model.
`timescale 1ns/1ps
module tb_count_sample_buffer;

    localparam int DEPTH = 120;
    localparam int AW    = 7;
    localparam int BW    = 27;
    localparam int SAT   = 99_999_999;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    count_sample_buffer_if #(.AW(AW), .BW(BW)) bus ();

    count_sample_buffer #(.DEPTH(DEPTH), .AW(AW), .BW(BW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: decimal values stored per address, pointer and peaks as plain integers.
    logic [BW:0] mem_m [DEPTH];
    int          wp_m, rp_m, fp_m;
    bit          ovf_seen_m;

    typedef struct {
        logic [31:0] bcd;
        bit          ovf_mid;
        logic [BW:0] exp;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int unsigned bcd_value(input logic [31:0] b);
        longint v = 0;
        longint w = 1;
        for (int i = 0; i < 8; i++) begin
            v += longint'(b[4*i +: 4]) * w;
            w *= 10;
        end
        return int'(v % (longint'(1) << BW));
    endfunction

    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            b[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_clear();
        wp_m = 0; rp_m = 0; fp_m = 0; ovf_seen_m = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " wr_ptr"},     64'(bus.wr_ptr),     0);
        check({tag, " sample_stb"}, 64'(bus.sample_stb), 0);
        check({tag, " frame_done"}, 64'(bus.frame_done), 0);
        check({tag, " frame_peak"}, 64'(bus.frame_peak), 0);
        check({tag, " busy"},       64'(bus.busy),       0);
        check({tag, " drop_err"},   64'(bus.drop_err),   0);
        check({tag, " rd_data"},    64'(bus.rd_data),    0);
        check({tag, " rd_valid"},   64'(bus.rd_valid),   0);
    endtask

    task automatic pulse_ovf();
        bus.ovf = 1'b1;
        tick();
        bus.ovf = 1'b0;
        ovf_seen_m = 1'b1;
    endtask

    task automatic drop_en();
        bus.en = 1'b0;
        tick();
        bus.en = 1'b1;
        model_clear();
    endtask

    // Full window: upd now, checks busy at T+1, quiet strobe at T+9, results at T+10.
    task automatic send(input logic [31:0] bcd, input bit ovf_now, input bit collide);
        bit          sat;
        int unsigned val;
        bit          done_exp;
        logic [BW:0] old;
        sat = ovf_seen_m | ovf_now;
        ovf_seen_m = 1'b0;
        val = sat ? SAT : bcd_value(bcd);
        old = '0;
        {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0} = bcd;
        bus.upd = 1'b1;
        bus.ovf = ovf_now;
        tick();
        bus.upd = 1'b0;
        bus.ovf = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (i == 1) check("busy in conv", 64'(bus.busy), 1);
            if (i == 9) begin
                check("stb early", 64'(bus.sample_stb), 0);
                if (collide) begin
                    bus.rd_en   = 1'b1;
                    bus.rd_addr = AW'(wp_m);
                    old = mem_m[wp_m];
                end
            end
            tick();
        end
        bus.rd_en = 1'b0;
        done_exp = (wp_m == DEPTH - 1);
        mem_m[wp_m] = {sat, BW'(val)};
        if (done_exp) begin
            fp_m = imax(rp_m, int'(val));
            rp_m = 0;
            wp_m = 0;
        end else begin
            rp_m = imax(rp_m, int'(val));
            wp_m++;
        end
        check("sample_stb",  64'(bus.sample_stb), 1);
        check("frame_done",  64'(bus.frame_done), 64'(done_exp));
        check("wr_ptr",      64'(bus.wr_ptr),     64'(wp_m));
        check("frame_peak",  64'(bus.frame_peak), 64'(fp_m));
        check("busy idle",   64'(bus.busy),       0);
        if (collide) begin
            check("collide rd_valid", 64'(bus.rd_valid), 1);
            check("collide old data", 64'(bus.rd_data),  64'(old));
        end
    endtask

    task automatic rd_check(input int addr, input logic [BW:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(addr);
        tick();
        bus.rd_en = 1'b0;
        check("rd_valid",   64'(bus.rd_valid), 1);
        check("rd_data",    64'(bus.rd_data),  64'(exp));
        tick();
        check("rd_valid off", 64'(bus.rd_valid), 0);
        check("rd_data hold", 64'(bus.rd_data),  64'(exp));
    endtask

    initial begin
        int          stb_cnt;
        int          old_wp;
        logic [31:0] bcd;

        vecs[0] = '{32'h1234_5678, 1'b0, {1'b0, 27'd12_345_678}};
        vecs[1] = '{32'h0000_0003, 1'b1, {1'b1, 27'd99_999_999}};
        vecs[2] = '{32'h0000_0003, 1'b0, {1'b0, 27'd3}};
        vecs[3] = '{32'h9999_9999, 1'b0, {1'b0, 27'd99_999_999}};
        vecs[4] = '{32'h0000_0000, 1'b0, {1'b0, 27'd0}};
        vecs[5] = '{32'h0000_00A0, 1'b0, {1'b0, 27'd100}};
        vecs[6] = '{32'hFFFF_FFFF, 1'b0, {1'b0, 27'd32_448_937}};

        rst_n = 1'b0;
        bus.en = 1'b0;
        {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0} = '0;
        bus.ovf = 1'b0;
        bus.upd = 1'b0;
        bus.rd_en = 1'b0;
        bus.rd_addr = '0;
        model_clear();
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        bus.en = 1'b1;
        tick();

        // Table vectors: conversion, overflow window, the following clean window, digit corners.
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].ovf_mid) begin
                tick();
                pulse_ovf();
                repeat (2) tick();
            end
            send(vecs[v].bcd, 1'b0, 1'b0);
            rd_check(v, vecs[v].exp);
        end

        // A pending carry is forgotten when en drops; memory survives.
        pulse_ovf();
        drop_en();
        check("en wr_ptr",     64'(bus.wr_ptr),     0);
        check("en frame_peak", 64'(bus.frame_peak), 0);
        check("en drop_err",   64'(bus.drop_err),   0);
        rd_check(0, {1'b0, 27'd12_345_678});

        // Second strobe 5 cycles into a conversion is dropped.
        {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0} = 32'h0000_0042;
        bus.upd = 1'b1;
        stb_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1 || i == 6) bus.upd = 1'b0;
            if (i == 5) begin
                {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0} = 32'h0000_0077;
                bus.upd = 1'b1;
            end
            if (bus.sample_stb) stb_cnt++;
        end
        mem_m[0] = {1'b0, 27'd42};
        rp_m = 42;
        wp_m = 1;
        check("b2b stb count", 64'(stb_cnt),       1);
        check("b2b drop_err",  64'(bus.drop_err),  1);
        check("b2b wr_ptr",    64'(bus.wr_ptr),    1);
        rd_check(0, {1'b0, 27'd42});

        drop_en();
        check("drop_err cleared", 64'(bus.drop_err), 0);
        send(32'h0000_1111, 1'b0, 1'b0);
        send(32'h0000_2222, 1'b0, 1'b0);
        check("spacing10 no drop", 64'(bus.drop_err), 0);
        rd_check(0, {1'b0, 27'd1111});
        rd_check(1, {1'b0, 27'd2222});

        // Frame wrap: counts 1..120 with a 500 spike at index 37.
        drop_en();
        for (int i = 0; i < DEPTH; i++) begin
            send(to_bcd((i == 37) ? 500 : i + 1), 1'b0, 1'b0);
        end
        check("wrap frame_done", 64'(bus.frame_done), 1);
        check("wrap frame_peak", 64'(bus.frame_peak), 500);
        check("wrap wr_ptr",     64'(bus.wr_ptr),     0);
        send(to_bcd(7777), 1'b0, 1'b0);
        rd_check(0, {1'b0, 27'd7777});
        rd_check(37, {1'b0, 27'd500});

        // Read corners: out-of-range addresses and a read colliding with the write.
        rd_check(120, '0);
        rd_check(127, '0);
        for (int i = 0; i < 4; i++) send(to_bcd(9000 + i), 1'b0, 1'b0);
        send(to_bcd(5555), 1'b0, 1'b1);
        rd_check(5, {1'b0, 27'd5555});

        // Async reset mid-conversion: outputs clear at once and the write never happens.
        old_wp = wp_m;
        {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0} = 32'h0000_0321;
        bus.upd = 1'b1;
        tick();
        bus.upd = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("async rst");
        tick();
        rst_n = 1'b1;
        model_clear();
        stb_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.sample_stb) stb_cnt++;
        end
        check("rst no write stb", 64'(stb_cnt),    0);
        check("rst wr_ptr",       64'(bus.wr_ptr), 0);
        rd_check(old_wp, mem_m[old_wp]);

        // Randomized windows, carries and reads against the model.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 4) == 0) pulse_ovf();
            for (int k = 0; k < 8; k++) begin
                bcd[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                           : 4'($urandom_range(0, 9));
            end
            send(bcd, ($urandom_range(0, 7) == 0), 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                old_wp = $urandom_range(0, 127);
                rd_check(old_wp, (old_wp >= DEPTH) ? '0 : mem_m[old_wp]);
            end
        end
        rd_check((wp_m == 0) ? DEPTH - 1 : wp_m - 1, mem_m[(wp_m == 0) ? DEPTH - 1 : wp_m - 1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
